// File: rtl/rgb_led_sequencer_pkg.sv
// Shared types and colour table for the RGB LED sequencer.
package rgb_led_pkg;

  localparam int NUM_COLOURS = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STATIC,
    S_RAMP_UP,
    S_HOLD,
    S_RAMP_DOWN,
    S_ADVANCE
  } state_e;

  // Table entry as a channel mask {b,g,r}; a set bit means that channel sits at max duty.
  function automatic logic [2:0] col_mask(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

endpackage

// File: rtl/rgb_led_sequencer_if.sv
// Control/status bundle between the LED control logic and the sequencer.
interface rgb_led_sequencer_if #(parameter int PWM_BITS = 8);
  logic                en;
  logic                mode;
  logic [PWM_BITS-1:0] col_r;
  logic [PWM_BITS-1:0] col_g;
  logic [PWM_BITS-1:0] col_b;
  logic                flash_req;
  logic                flash_ack;
  logic                pwm_r;
  logic                pwm_g;
  logic                pwm_b;
  logic                led_en;
  logic [1:0]          colour_idx;
  logic                busy;

  modport master (
    output en, mode, col_r, col_g, col_b, flash_req,
    input  flash_ack, pwm_r, pwm_g, pwm_b, led_en, colour_idx, busy
  );

  modport slave (
    input  en, mode, col_r, col_g, col_b, flash_req,
    output flash_ack, pwm_r, pwm_g, pwm_b, led_en, colour_idx, busy
  );
endinterface

// File: rtl/rgb_led_sequencer_pwm3.sv
// Three-channel PWM: shared free-running counter, per-channel shadowed duty and registered compare.
module rgb_pwm3 #(
  parameter int PWM_BITS = 8
) (
  input  logic                     hw_clk,
  input  logic                     rst,
  input  logic [2:0][PWM_BITS-1:0] duty_i,
  output logic [2:0]               pwm_o
);

  logic [PWM_BITS-1:0]      cnt_q;
  logic [2:0][PWM_BITS-1:0] duty_sh_q;
  logic [2:0]               pwm_q;

  always_ff @(posedge hw_clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Shadow loads only on the last count so a period never mixes two duties.
  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    always_ff @(posedge hw_clk or posedge rst) begin
      if (rst) begin
        duty_sh_q[ch] <= '0;
        pwm_q[ch]     <= 1'b0;
      end else begin
        if (&cnt_q) duty_sh_q[ch] <= duty_i[ch];
        pwm_q[ch] <= (cnt_q < duty_sh_q[ch]);
      end
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_led_sequencer.sv
// LED sequencer top: step prescaler, colour FSM, level scaling and flash arbiter feeding rgb_pwm3.
module rgb_led_sequencer
  import rgb_led_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int STEP_DIV    = 46875,
  parameter int HOLD_STEPS  = 64,
  parameter int FLASH_STEPS = 16
) (
  input  logic                hw_clk,
  input  logic                rst,
  rgb_led_sequencer_if.slave  bus
);

  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int HLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam int FL_W  = $clog2(FLASH_STEPS + 1);
  localparam logic [PWM_BITS-1:0] MAXV = {PWM_BITS{1'b1}};

  logic [PRE_W-1:0]    presc_q;
  logic                step;
  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [1:0]          idx_q, idx_d;
  logic [HLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic                flash_act_q, flash_ack_q, accept;
  logic [FL_W-1:0]     flash_cnt_q;

  assign step = (presc_q == PRE_W'(STEP_DIV - 1));

  always_ff @(posedge hw_clk or posedge rst) begin
    if (rst)       presc_q <= '0;
    else if (step) presc_q <= '0;
    else           presc_q <= presc_q + 1'b1;
  end

  always_ff @(posedge hw_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      level_q    <= '0;
      idx_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // en drop beats everything, including an active flash; otherwise a flash freezes the sequencer.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    if (!bus.en) begin
      state_d    = S_IDLE;
      level_d    = '0;
      idx_d      = '0;
      hold_cnt_d = '0;
    end else if (!flash_act_q) begin
      case (state_q)
        S_IDLE, S_STATIC: begin
          if (bus.mode) begin
            state_d    = S_RAMP_UP;
            level_d    = '0;
            idx_d      = '0;
            hold_cnt_d = '0;
          end else begin
            state_d = S_STATIC;
          end
        end
        default: begin
          if (!bus.mode) begin
            state_d = S_STATIC;
          end else begin
            case (state_q)
              S_RAMP_UP: if (step) begin
                level_d = level_q + 1'b1;
                if (level_q == MAXV - 1'b1) begin
                  state_d    = S_HOLD;
                  hold_cnt_d = '0;
                end
              end
              S_HOLD: if (step) begin
                if (hold_cnt_q == HLD_W'(HOLD_STEPS - 1)) state_d = S_RAMP_DOWN;
                else                                     hold_cnt_d = hold_cnt_q + 1'b1;
              end
              S_RAMP_DOWN: if (step) begin
                level_d = level_q - 1'b1;
                if (level_q == PWM_BITS'(1)) state_d = S_ADVANCE;
              end
              S_ADVANCE: begin
                idx_d   = (idx_q == 2'(NUM_COLOURS - 1)) ? 2'd0 : idx_q + 1'b1;
                state_d = S_RAMP_UP;
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign accept = bus.flash_req & ~flash_act_q;

  always_ff @(posedge hw_clk or posedge rst) begin
    if (rst) begin
      flash_act_q <= 1'b0;
      flash_cnt_q <= '0;
      flash_ack_q <= 1'b0;
    end else begin
      flash_ack_q <= accept;
      if (accept) begin
        flash_act_q <= 1'b1;
        flash_cnt_q <= FL_W'(FLASH_STEPS);
      end else if (flash_act_q && step) begin
        flash_cnt_q <= flash_cnt_q - 1'b1;
        if (flash_cnt_q == FL_W'(1)) flash_act_q <= 1'b0;
      end
    end
  end

  logic [2*PWM_BITS-1:0]    prod;
  logic [PWM_BITS-1:0]      scaled;
  logic [2:0]               mask;
  logic [2:0][PWM_BITS-1:0] duty;
  logic [2:0]               pwm;

  assign prod   = {{PWM_BITS{1'b0}}, MAXV} * {{PWM_BITS{1'b0}}, level_q};
  assign scaled = prod[2*PWM_BITS-1:PWM_BITS];
  assign mask   = col_mask(idx_q);

  always_comb begin
    duty = '0;
    if (flash_act_q) begin
      duty = {3{MAXV}};
    end else if (state_q == S_STATIC) begin
      duty = {bus.col_b, bus.col_g, bus.col_r};
    end else if (state_q != S_IDLE) begin
      for (int ch = 0; ch < 3; ch++) duty[ch] = mask[ch] ? scaled : '0;
    end
  end

  rgb_pwm3 #(.PWM_BITS(PWM_BITS)) u_pwm (
    .hw_clk (hw_clk),
    .rst    (rst),
    .duty_i (duty),
    .pwm_o  (pwm)
  );

  // led_en tracks the FSM rather than raw en so reset holds it low.
  assign bus.pwm_r      = pwm[0];
  assign bus.pwm_g      = pwm[1];
  assign bus.pwm_b      = pwm[2];
  assign bus.flash_ack  = flash_ack_q;
  assign bus.led_en     = (state_q != S_IDLE) | flash_act_q;
  assign bus.colour_idx = idx_q;
  assign bus.busy       = flash_act_q | ((state_q != S_IDLE) && (state_q != S_STATIC));

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Directed bench for rgb_led_sequencer at PWM_BITS=4, STEP_DIV=2, HOLD_STEPS=2, FLASH_STEPS=3.
module tb_rgb_led_sequencer;
  import rgb_led_pkg::*;

  localparam int F = 192;

  logic hw_clk = 1'b0;
  logic rst    = 1'b1;
  int   n_chk  = 0;
  int   n_bad  = 0;

  rgb_led_sequencer_if #(.PWM_BITS(4)) bus ();

  rgb_led_sequencer #(
    .PWM_BITS(4), .STEP_DIV(2), .HOLD_STEPS(2), .FLASH_STEPS(3)
  ) dut (
    .hw_clk (hw_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 hw_clk = ~hw_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int outs_sum();
    return int'(bus.pwm_r) + int'(bus.pwm_g) + int'(bus.pwm_b) + int'(bus.led_en)
         + int'(bus.busy) + int'(bus.flash_ack) + int'(bus.colour_idx);
  endfunction

  initial begin
    int  cr, cg, cb, acc, acks, fl;
    int  wr[3], wg[3], wb[3];
    logic prev, found;

    bus.en = 1'b0; bus.mode = 1'b0; bus.flash_req = 1'b0;
    bus.col_r = 4'd15; bus.col_g = 4'd8; bus.col_b = 4'd0;

    // 1. reset and dark idle
    repeat (3) @(negedge hw_clk);
    chk("rst_outs", outs_sum(), 0);
    rst = 1'b0;
    acc = 0;
    repeat (40) begin @(negedge hw_clk); acc += outs_sum(); end
    chk("idle_dark", acc, 0);

    // 2. static colour
    bus.en = 1'b1;
    repeat (40) @(negedge hw_clk);
    cr = 0; cg = 0; cb = 0; acc = 0;
    repeat (16) begin
      @(negedge hw_clk);
      cr += bus.pwm_r; cg += bus.pwm_g; cb += bus.pwm_b; acc += bus.led_en;
    end
    chk("static_r", cr, 15);
    chk("static_g", cg, 8);
    chk("static_b", cb, 0);
    chk("static_led_en", acc, 16);
    chk("static_busy", bus.busy, 0);

    // 3. duty change mid-period waits for the wrap
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      prev = bus.pwm_g;
      @(negedge hw_clk);
      if (!prev && bus.pwm_g) found = 1'b1;
    end
    chk("g_rise_seen", found, 1);
    bus.col_g = 4'd4;
    cg = 0;
    repeat (15) begin @(negedge hw_clk); cg += bus.pwm_g; end
    chk("g_old_period", cg, 7);
    cg = 0;
    repeat (16) begin @(negedge hw_clk); cg += bus.pwm_g; end
    chk("g_new_period", cg, 4);

    // 4-6. breathing sequence, flash during HOLD, en drop on a step
    bus.mode = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge hw_clk);
      if (bus.colour_idx == 2'd1) found = 1'b1;
    end
    chk("idx1_seen", found, 1);
    for (int w = 0; w < 3; w++) begin wr[w] = 0; wg[w] = 0; wb[w] = 0; end
    acks = 0; fl = 0;
    for (int k = 0; k <= F + 78; k++) begin
      if (k > 0) @(negedge hw_clk);
      for (int w = 0; w < 3; w++) begin
        if (k >= 20 + 64 * w && k < 64 + 64 * w) begin
          wr[w] += bus.pwm_r; wg[w] += bus.pwm_g; wb[w] += bus.pwm_b;
        end
      end
      if (k == 0)      chk("lvl_start", dut.level_q, 0);
      if (k == 27)     chk("lvl_14", dut.level_q, 14);
      if (k == 29) begin
        chk("lvl_15", dut.level_q, 15);
        chk("st_hold", int'(dut.state_q), int'(S_HOLD));
      end
      if (k == 33) begin
        chk("st_down", int'(dut.state_q), int'(S_RAMP_DOWN));
        chk("lvl_down_start", dut.level_q, 15);
      end
      if (k == 63)     chk("idx_still1", bus.colour_idx, 1);
      if (k == 64)     chk("idx_2", bus.colour_idx, 2);
      if (k == 128)    chk("idx_0", bus.colour_idx, 0);
      if (k == F)      chk("idx_1_again", bus.colour_idx, 1);
      if (k >= F && k <= F + 60) acks += bus.flash_ack;
      if (k >= F + 30 && k < F + 38) fl += dut.flash_act_q;
      if (k == F + 31) chk("ack1", bus.flash_ack, 1);
      if (k == F + 32) chk("ack1_pulse", bus.flash_ack, 0);
      if (k == F + 33) chk("flash_led_en", bus.led_en, 1);
      if (k == F + 35) chk("hold_frozen", dut.hold_cnt_q, 1);
      if (k == F + 38) begin
        chk("ack2", bus.flash_ack, 1);
        bus.flash_req = 1'b0;
      end
      if (k == F + 44) chk("resume_hold", int'(dut.state_q), int'(S_HOLD));
      if (k == F + 45) chk("resume_down", int'(dut.state_q), int'(S_RAMP_DOWN));
      if (k == F + 75) chk("idx1_late", bus.colour_idx, 1);
      if (k == F + 76) chk("idx2_late", bus.colour_idx, 2);
      if (k == F + 78) begin
        chk("ramp_lvl1", dut.level_q, 1);
        bus.en = 1'b0;
      end
      if (k == F + 30) bus.flash_req = 1'b1;
    end
    chk("w_idx1_r", wr[0], 0);
    chk("w_idx1_g", wg[0] > 0, 1);
    chk("w_idx1_b", wb[0], 0);
    chk("w_idx2_r", wr[1], 0);
    chk("w_idx2_g", wg[1], 0);
    chk("w_idx2_b", wb[1] > 0, 1);
    chk("w_idx0_r", wr[2] > 0, 1);
    chk("w_idx0_g", wg[2], 0);
    chk("w_idx0_b", wb[2], 0);
    chk("ack_count", acks, 2);
    chk("flash_len", fl, 6);

    @(negedge hw_clk);
    chk("off_state", int'(dut.state_q), int'(S_IDLE));
    chk("off_level", dut.level_q, 0);
    chk("off_idx", bus.colour_idx, 0);
    chk("off_busy", bus.busy, 0);
    chk("off_led_en", bus.led_en, 0);
    repeat (17) @(negedge hw_clk);
    acc = 0;
    repeat (16) begin @(negedge hw_clk); acc += bus.pwm_r + bus.pwm_g + bus.pwm_b; end
    chk("off_pwm", acc, 0);

    // async reset mid-ramp
    bus.en = 1'b1;
    repeat (20) @(negedge hw_clk);
    chk("ramp_busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1 chk("rst_async", outs_sum(), 0);
    @(negedge hw_clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
